// File: rtl/m_ask_modulator.sv
// M-ASK modulator: groups a serial bit stream into 1/2/3-bit symbols and
// scales a DDS sine carrier by (symbol+1)/2^k around mid-scale.
module m_ask_modulator #(
    parameter int BIT_DIV    = 25000,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 8,
    parameter int OUT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               message,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [OUT_W-1:0]   modulated,
    output logic [2:0]         symbol,
    output logic               sym_valid,
    output logic               bit_tick
);
    localparam int CNT_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int LUT_N  = 1 << LUT_ADDR_W;
    localparam int PROD_W = OUT_W + 4;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PHASE_W-1:0]       r_phaseAcc;
    logic [CNT_W-1:0]         r_bitCnt;
    logic [1:0]               r_bitsInSym;
    logic [1:0]               r_shift;
    logic [1:0]               r_activeK;
    logic [1:0]               r_symK;
    logic [2:0]               r_symbol;
    logic                     r_symValid;
    logic signed [OUT_W-1:0]  r_lutQ;
    logic signed [PROD_W-1:0] r_prod;
    logic [1:0]               r_prodK;
    logic [OUT_W-1:0]         r_modulated;

    logic                     w_bitTick;
    logic                     w_lastBit;
    logic [2:0]               w_assembled;
    logic [1:0]               w_nextK;
    logic [LUT_ADDR_W-1:0]    w_lutAddr;
    logic [3:0]               w_amp;
    logic signed [PROD_W-1:0] w_lutExt;
    logic signed [PROD_W-1:0] w_ampExt;
    logic signed [PROD_W-1:0] w_prodFull;
    logic [OUT_W-1:0]         w_shifted;

    // Sine table built at elaboration, rounded half away from zero.
    logic signed [OUT_W-1:0] w_lut [LUT_N];
    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        localparam real    ANGLE  = 2.0 * 3.14159265358979323846 * i / LUT_N;
        localparam real    SCALED = ((2.0 ** (OUT_W - 1)) - 1.0) * $sin(ANGLE);
        localparam integer VALUE  = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5)
                                                    : -$rtoi(0.5 - SCALED);
        assign w_lut[i] = OUT_W'(VALUE);
    end

    assign w_bitTick = en && (r_bitCnt == CNT_W'(BIT_DIV - 1));
    assign w_lastBit = (r_bitsInSym == (r_activeK - 2'd1));
    assign w_nextK   = (mode == 2'd3) ? 2'd2 : mode + 2'd1;

    // The bit arriving now completes the symbol, so it joins the held bits directly.
    always_comb begin
        w_assembled = {2'b00, message};
        case (r_activeK)
            2'd2:    w_assembled = {1'b0, r_shift[0], message};
            2'd3:    w_assembled = {r_shift, message};
            default: w_assembled = {2'b00, message};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phaseAcc <= '0;
        end else if (en) begin
            r_phaseAcc <= r_phaseAcc + phase_inc;
        end
    end

    // r_symK remembers the width a symbol was built with, since mode may already be new.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitCnt    <= '0;
            r_bitsInSym <= '0;
            r_shift     <= '0;
            r_activeK   <= 2'd2;
            r_symK      <= 2'd2;
            r_symbol    <= '0;
            r_symValid  <= 1'b0;
        end else begin
            r_symValid <= 1'b0;
            if (w_bitTick) begin
                r_bitCnt <= '0;
                r_shift  <= {r_shift[0], message};
                if (w_lastBit) begin
                    r_symbol    <= w_assembled;
                    r_symK      <= r_activeK;
                    r_activeK   <= w_nextK;
                    r_bitsInSym <= '0;
                    r_symValid  <= 1'b1;
                end else begin
                    r_bitsInSym <= r_bitsInSym + 2'd1;
                end
            end else if (en) begin
                r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
        end
    end

    assign w_lutAddr  = r_phaseAcc[PHASE_W-1 -: LUT_ADDR_W];
    assign w_amp      = {1'b0, r_symbol} + 4'd1;
    assign w_lutExt   = {{(PROD_W-OUT_W){r_lutQ[OUT_W-1]}}, r_lutQ};
    assign w_ampExt   = {{(PROD_W-4){1'b0}}, w_amp};
    assign w_prodFull = w_lutExt * w_ampExt;
    assign w_shifted  = OUT_W'(r_prod >>> r_prodK);

    // Three-stage datapath keeps running while disabled so it drains cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lutQ      <= '0;
            r_prod      <= '0;
            r_prodK     <= 2'd2;
            r_modulated <= MID;
        end else begin
            r_lutQ      <= w_lut[w_lutAddr];
            r_prod      <= w_prodFull;
            r_prodK     <= r_symK;
            r_modulated <= en ? (w_shifted + MID) : MID;
        end
    end

    assign modulated = r_modulated;
    assign symbol    = r_symbol;
    assign sym_valid = r_symValid;
    assign bit_tick  = w_bitTick;

endmodule
